// File: rtl/z80_bus_pkg.sv
// Shared types and widths for the Z80 bus-master DMA block.
package z80_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SETUP,
    STROBE,
    DONE,
    HOLD,
    RELEASE
  } dma_state_t;

  // Saturating increment used for every cycle counter in the block.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchroniser for asynchronous single-bit CPU inputs.
module sync_ff #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/z80_bus_dma.sv
// Bus-master controller: borrows the A-Z80 bus via nBUSRQ/nBUSACK and runs
// single-byte memory reads/writes for an on-chip requester.
module z80_bus_dma
  import z80_bus_pkg::*;
#(
  parameter int unsigned ACC_CYCLES  = 2,
  parameter int unsigned IDLE_HOLD   = 4,
  parameter int unsigned ACK_TIMEOUT = 1023,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              err,
  output logic              nBUSRQ,
  input  logic              nBUSACK,
  output logic              bus_oe,
  output logic [ADDR_W-1:0] bus_A,
  output logic [DATA_W-1:0] bus_D_out,
  output logic              bus_D_oe,
  input  logic [DATA_W-1:0] bus_D_in,
  output logic              bus_nMREQ,
  output logic              bus_nRD,
  output logic              bus_nWR
);

  localparam logic [15:0] AckTimeoutC = 16'(ACK_TIMEOUT);
  localparam logic [15:0] IdleHoldC   = 16'(IDLE_HOLD);
  localparam logic [15:0] AccLastC    = 16'(ACC_CYCLES - 1);

  logic ack;

  sync_ff #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_ack_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (nBUSACK),
    .q_o  (ack)
  );

  dma_state_t        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              nbusrq_q, nbusrq_d;
  logic              bus_oe_q, bus_oe_d;
  logic [ADDR_W-1:0] bus_a_q, bus_a_d;
  logic [DATA_W-1:0] bus_d_out_q, bus_d_out_d;
  logic              bus_d_oe_q, bus_d_oe_d;
  logic              nmreq_q, nmreq_d;
  logic              nrd_q, nrd_d;
  logic              nwr_q, nwr_d;
  logic              write_q, write_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              err_q, err_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = sat_inc(cnt_q);
    nbusrq_d    = nbusrq_q;
    bus_oe_d    = bus_oe_q;
    bus_a_d     = bus_a_q;
    bus_d_out_d = bus_d_out_q;
    write_d     = write_q;
    nmreq_d     = 1'b1;
    nrd_d       = 1'b1;
    nwr_d       = 1'b1;
    bus_d_oe_d  = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d  = REQ;
          nbusrq_d = 1'b0;
          cnt_d    = '0;
        end
      end
      REQ: begin
        if (!ack) begin
          state_d  = SETUP;
          bus_oe_d = 1'b1;
        end else if (cnt_q == AckTimeoutC) begin
          state_d = RELEASE;
          err_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        if (ack) begin
          state_d  = RELEASE;
          bus_oe_d = 1'b0;
          err_d    = 1'b1;
          cnt_d    = '0;
        end else if (req_valid) begin
          state_d     = STROBE;
          cnt_d       = '0;
          write_d     = req_write;
          bus_a_d     = req_addr;
          bus_d_out_d = req_wdata;
          nmreq_d     = 1'b0;
          nrd_d       = req_write;
          nwr_d       = !req_write;
          bus_d_oe_d  = req_write;
        end else begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      STROBE: begin
        if (ack) begin
          state_d  = RELEASE;
          bus_oe_d = 1'b0;
          err_d    = 1'b1;
          cnt_d    = '0;
        end else if (cnt_q == AccLastC) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          if (!write_q) begin
            rsp_rdata_d = bus_D_in;
          end
        end else begin
          nmreq_d    = 1'b0;
          nrd_d      = write_q;
          nwr_d      = !write_q;
          bus_d_oe_d = write_q;
        end
      end
      DONE: begin
        // A pending request skips HOLD so back-to-back transfers cost ACC_CYCLES+2.
        cnt_d   = '0;
        state_d = req_valid ? SETUP : HOLD;
      end
      HOLD: begin
        if (ack) begin
          state_d  = RELEASE;
          bus_oe_d = 1'b0;
          err_d    = 1'b1;
          cnt_d    = '0;
        end else if (req_valid) begin
          state_d = SETUP;
        end else if (cnt_q == IdleHoldC) begin
          state_d  = RELEASE;
          bus_oe_d = 1'b0;
          cnt_d    = '0;
        end
      end
      RELEASE: begin
        // bus_oe already dropped on entry; nBUSRQ follows one cycle later.
        nbusrq_d = 1'b1;
        if (nbusrq_q && ack) begin
          state_d = IDLE;
        end else if (cnt_q == AckTimeoutC) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      nbusrq_q    <= 1'b1;
      bus_oe_q    <= 1'b0;
      bus_a_q     <= '0;
      bus_d_out_q <= '0;
      bus_d_oe_q  <= 1'b0;
      nmreq_q     <= 1'b1;
      nrd_q       <= 1'b1;
      nwr_q       <= 1'b1;
      write_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nbusrq_q    <= nbusrq_d;
      bus_oe_q    <= bus_oe_d;
      bus_a_q     <= bus_a_d;
      bus_d_out_q <= bus_d_out_d;
      bus_d_oe_q  <= bus_d_oe_d;
      nmreq_q     <= nmreq_d;
      nrd_q       <= nrd_d;
      nwr_q       <= nwr_d;
      write_q     <= write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = (state_q == SETUP) && !ack;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign err       = err_q;
  assign nBUSRQ    = nbusrq_q;
  assign bus_oe    = bus_oe_q;
  assign bus_A     = bus_a_q;
  assign bus_D_out = bus_d_out_q;
  assign bus_D_oe  = bus_d_oe_q;
  assign bus_nMREQ = nmreq_q;
  assign bus_nRD   = nrd_q;
  assign bus_nWR   = nwr_q;

endmodule

// File: tb/tb_z80_bus_dma.sv
// Directed bench for z80_bus_dma with a simple CPU grant model and a one-word RAM model.
module tb_z80_bus_dma;

  localparam int ACC_CYCLES  = 2;
  localparam int IDLE_HOLD   = 4;
  localparam int ACK_TIMEOUT = 1023;
  localparam int SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        err;
  logic        nBUSRQ, nBUSACK;
  logic        bus_oe;
  logic [15:0] bus_A;
  logic [7:0]  bus_D_out, bus_D_in;
  logic        bus_D_oe, bus_nMREQ, bus_nRD, bus_nWR;

  z80_bus_dma #(
    .ACC_CYCLES (ACC_CYCLES),
    .IDLE_HOLD  (IDLE_HOLD),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .err      (err),
    .nBUSRQ   (nBUSRQ),
    .nBUSACK  (nBUSACK),
    .bus_oe   (bus_oe),
    .bus_A    (bus_A),
    .bus_D_out(bus_D_out),
    .bus_D_oe (bus_D_oe),
    .bus_D_in (bus_D_in),
    .bus_nMREQ(bus_nMREQ),
    .bus_nRD  (bus_nRD),
    .bus_nWR  (bus_nWR)
  );

  always #5 clk = ~clk;

  // CPU model: grants 3 clocks after nBUSRQ falls, releases when nBUSRQ rises.
  logic cpu_en, cpu_drop, cpu_ack_n;
  int   gcnt;
  always @(posedge clk) begin
    if (!cpu_en || nBUSRQ) begin
      cpu_ack_n <= 1'b1;
      gcnt      <= 0;
    end else if (gcnt == 2) begin
      cpu_ack_n <= 1'b0;
    end else begin
      gcnt <= gcnt + 1;
    end
  end
  assign nBUSACK  = cpu_ack_n | cpu_drop;
  assign bus_D_in = (bus_A == 16'h03FF) ? 8'h5A : 8'h00;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int n_wr, n_rd, n_mreq, n_rsp, n_err, n_oe, n_doe, n_viol, n_rq_rise, n_grant, n_wrfall;
  int wr_fall[8];
  int rsp_cyc, oe_rise, oe_fall, rq_rise, rq_fall, err_cyc;
  logic prev_nwr, prev_oe, prev_rq, prev_ack;
  logic [15:0] last_wa;
  logic [7:0]  last_wd, last_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_wr = 0; n_rd = 0; n_mreq = 0; n_rsp = 0; n_err = 0; n_oe = 0; n_doe = 0; n_viol = 0;
    n_rq_rise = 0; n_grant = 0; n_wrfall = 0;
    rsp_cyc = -1; oe_rise = -1; oe_fall = -1; rq_rise = -1; rq_fall = -1; err_cyc = -1;
    prev_nwr = bus_nWR; prev_oe = bus_oe; prev_rq = nBUSRQ; prev_ack = nBUSACK;
    last_wa = '0; last_wd = '0;
  endtask

  // One clock: sample on the falling edge and accumulate observations.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!bus_nWR) begin
      n_wr++;
      last_wa = bus_A;
      last_wd = bus_D_out;
      if (!bus_D_oe) n_viol++;
    end
    if (!bus_nRD) n_rd++;
    if (!bus_nMREQ) n_mreq++;
    if (bus_D_oe) n_doe++;
    if (rsp_valid) begin
      n_rsp++;
      rsp_cyc    = cyc;
      last_rdata = rsp_rdata;
    end
    if (err) begin
      n_err++;
      if (err_cyc < 0) err_cyc = cyc;
    end
    if (bus_oe) n_oe++;
    if (!bus_oe && (!bus_nMREQ || !bus_nRD || !bus_nWR)) n_viol++;
    if (!bus_nWR && prev_nwr && n_wrfall < 8) begin
      wr_fall[n_wrfall] = cyc;
      n_wrfall++;
    end
    if (bus_oe && !prev_oe) oe_rise = cyc;
    if (!bus_oe && prev_oe) oe_fall = cyc;
    if (nBUSRQ && !prev_rq) begin
      n_rq_rise++;
      rq_rise = cyc;
    end
    if (!nBUSRQ && prev_rq) rq_fall = cyc;
    if (!nBUSACK && prev_ack) n_grant++;
    prev_nwr = bus_nWR; prev_oe = bus_oe; prev_rq = nBUSRQ; prev_ack = nBUSACK;
  endtask

  // Present a request and hold it until the accepting clock edge has passed.
  task automatic send(input logic w, input logic [15:0] a, input logic [7:0] d);
    int k;
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (!req_ready && k < 100);
    check("accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    cpu_en = 1'b1; cpu_drop = 1'b0;
    clear_stats();
    tick(); tick();
    check("rst_nbusrq", 32'(nBUSRQ), 32'd1);
    check("rst_oe", {bus_oe, bus_D_oe}, 32'd0);
    check("rst_strobes", {bus_nMREQ, bus_nRD, bus_nWR}, 32'h7);
    check("rst_addr_data", {bus_A, bus_D_out}, 32'd0);
    check("rst_rsp", {req_ready, rsp_valid, err, rsp_rdata}, 32'd0);
    reset = 1'b0;
    repeat (3) tick();

    // Write 0x0123 <= 0xA5
    clear_stats();
    send(1'b1, 16'h0123, 8'hA5);
    req_valid = 1'b0;
    repeat (30) tick();
    check("wr_nwr_cycles", 32'(n_wr), 32'(ACC_CYCLES));
    check("wr_nmreq_cycles", 32'(n_mreq), 32'(ACC_CYCLES));
    check("wr_nrd_cycles", 32'(n_rd), 32'd0);
    check("wr_addr", 32'(last_wa), 32'h0123);
    check("wr_data", 32'(last_wd), 32'hA5);
    check("wr_rsp_count", 32'(n_rsp), 32'd1);
    check("wr_err_count", 32'(n_err), 32'd0);
    check("wr_setup_to_strobe", 32'(wr_fall[0] - oe_rise), 32'd1);
    check("wr_idle_release", 32'(oe_fall - rsp_cyc), 32'(IDLE_HOLD + 2));
    check("wr_oe_then_busrq", 32'(rq_rise - oe_fall), 32'd1);
    check("wr_viol", 32'(n_viol), 32'd0);
    check("wr_final_busrq", {nBUSRQ, bus_oe}, 32'h2);

    // Read 0x03FF -> 0x5A
    clear_stats();
    send(1'b0, 16'h03FF, 8'h00);
    req_valid = 1'b0;
    repeat (30) tick();
    check("rd_nrd_cycles", 32'(n_rd), 32'(ACC_CYCLES));
    check("rd_nwr_cycles", 32'(n_wr), 32'd0);
    check("rd_doe_cycles", 32'(n_doe), 32'd0);
    check("rd_rsp_count", 32'(n_rsp), 32'd1);
    check("rd_data", 32'(last_rdata), 32'h5A);
    check("rd_held", 32'(rsp_rdata), 32'h5A);

    // Burst of three writes while the bus is held
    clear_stats();
    send(1'b1, 16'h1000, 8'h11);
    send(1'b1, 16'h1001, 8'h22);
    send(1'b1, 16'h1002, 8'h33);
    req_valid = 1'b0;
    repeat (40) tick();
    check("burst_strobe_count", 32'(n_wrfall), 32'd3);
    check("burst_space_1", 32'(wr_fall[1] - wr_fall[0]), 32'(ACC_CYCLES + 2));
    check("burst_space_2", 32'(wr_fall[2] - wr_fall[1]), 32'(ACC_CYCLES + 2));
    check("burst_grants", 32'(n_grant), 32'd1);
    check("burst_busrq_rises", 32'(n_rq_rise), 32'd1);
    check("burst_rsp_count", 32'(n_rsp), 32'd3);
    check("burst_last", {last_wa, last_wd}, 32'h100233);
    check("burst_viol", 32'(n_viol), 32'd0);

    // Grant never arrives
    clear_stats();
    cpu_en = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0042;
    for (int i = 0; i < 1200 && err_cyc < 0; i++) tick();
    req_valid = 1'b0;
    check("to_latency", 32'(err_cyc - rq_fall), 32'(ACK_TIMEOUT + 1));
    repeat (10) tick();
    check("to_err_count", 32'(n_err), 32'd1);
    check("to_oe_never", 32'(n_oe), 32'd0);
    check("to_no_strobes", 32'(n_mreq + n_rd + n_wr), 32'd0);
    check("to_rsp_count", 32'(n_rsp), 32'd0);
    check("to_busrq_back", 32'(nBUSRQ), 32'd1);
    cpu_en = 1'b1;

    // CPU reclaims the bus during a read
    clear_stats();
    req_write = 1'b0; req_addr = 16'h2000; req_valid = 1'b1;
    s = 0;
    do begin
      tick();
      s++;
    end while (!req_ready && s < 100);
    check("ab_accept", 32'(req_ready), 32'd1);
    s = cyc;
    cpu_drop = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus_nRD) break;
    end
    check("ab_strobe_high_lat", 32'(cyc - s), 32'(SYNC_STAGES + 1));
    repeat (10) tick();
    cpu_drop = 1'b0;
    check("ab_err_count", 32'(n_err), 32'd1);
    check("ab_rsp_count", 32'(n_rsp), 32'd0);
    check("ab_idle", {nBUSRQ, bus_oe, bus_nMREQ, bus_nRD}, 32'hB);
    check("ab_viol", 32'(n_viol), 32'd0);

    // Asynchronous reset in the middle of a write strobe
    clear_stats();
    send(1'b1, 16'h4444, 8'h77);
    req_valid = 1'b0;
    for (int i = 0; i < 20 && bus_nWR; i++) tick();
    check("rs_in_strobe", 32'(bus_nWR), 32'd0);
    reset = 1'b1;
    #1;
    check("rs_strobes", {bus_nMREQ, bus_nRD, bus_nWR}, 32'h7);
    check("rs_bus", {nBUSRQ, bus_oe, bus_D_oe}, 32'h4);
    check("rs_rdata_cleared", 32'(rsp_rdata), 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    clear_stats();
    send(1'b0, 16'h03FF, 8'h00);
    req_valid = 1'b0;
    repeat (30) tick();
    check("rs_after_rsp", 32'(n_rsp), 32'd1);
    check("rs_after_data", 32'(last_rdata), 32'h5A);
    check("rs_after_release", {nBUSRQ, bus_oe}, 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
